// File: rtl/elevator_ctrl.sv
// Elevator controller: latches per-floor calls, serves them with a SCAN
// sweep, and times travel and door phases from a 1 s tick derived from
// the 10 Hz clock.
// Optional feature macro: ELEV_DOOR_HOLD_EN adds the door_hold input,
// which keeps the door open while asserted.
module elevator_ctrl #(
    parameter int FLOORS     = 4,
    parameter int TICK_DIV   = 10,
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 3,
    localparam int FW        = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
    input  logic              clk10hz,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] req,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic              door_hold,
`endif
    output logic [FW-1:0]     curr_floor,
    output logic [FLOORS-1:0] pending,
    output logic [1:0]        running_state,
    output logic [1:0]        door_state,
    output logic [1:0]        state
);

    localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE         = 2'b00,
        S_MOVING       = 2'b01,
        S_DOOR_OPEN    = 2'b10,
        S_DOOR_CLOSING = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic              dir_q, dir_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PW-1:0]     presc_q, presc_d;

    logic [FLOORS-1:0] req_eff;
    logic [FLOORS-1:0] pend_eff;
    logic              door_restart;
    logic              tick;
    logic              hold_in;
    logic [FW-1:0]     step_floor;
    int                du, dd, du_n, dd_n;
    logic              has_up, has_dn, has_up_n, has_dn_n;
    logic              ahead_n, behind_n;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold_in = door_hold;
`else
    assign hold_in = 1'b0;
`endif

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // Distance to the nearest pending floor above f, FLOORS when none.
    function automatic int dist_up(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        int d;
        d = FLOORS;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if ((i > int'(f)) && p[i]) d = i - int'(f);
        end
        return d;
    endfunction

    // Distance to the nearest pending floor below f, FLOORS when none.
    function automatic int dist_dn(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        int d;
        d = FLOORS;
        for (int i = 0; i < FLOORS; i++) begin
            if ((i < int'(f)) && p[i]) d = int'(f) - i;
        end
        return d;
    endfunction

    // Next-state logic: call latching, floor stepping, SCAN direction and phase timers.
    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        dir_d        = dir_q;
        timer_d      = timer_q;
        req_eff      = req;
        door_restart = 1'b0;

        if ((state_q == S_DOOR_OPEN) && req[floor_q]) begin
            req_eff[floor_q] = 1'b0;
            door_restart     = 1'b1;
        end
        pend_eff  = pending_q | req_eff;
        pending_d = pend_eff;

        du     = dist_up(pend_eff, floor_q);
        dd     = dist_dn(pend_eff, floor_q);
        has_up = (du < FLOORS);
        has_dn = (dd < FLOORS);

        if (dir_q) begin
            step_floor = (floor_q < FW'(FLOORS - 1)) ? floor_q + FW'(1) : floor_q;
        end else begin
            step_floor = (floor_q != '0) ? floor_q - FW'(1) : floor_q;
        end
        du_n     = dist_up(pend_eff, step_floor);
        dd_n     = dist_dn(pend_eff, step_floor);
        has_up_n = (du_n < FLOORS);
        has_dn_n = (dd_n < FLOORS);
        ahead_n  = dir_q ? has_up_n : has_dn_n;
        behind_n = dir_q ? has_dn_n : has_up_n;

        case (state_q)
            S_IDLE: begin
                if (pend_eff[floor_q]) begin
                    pending_d[floor_q] = 1'b0;
                    state_d            = S_DOOR_OPEN;
                    timer_d            = '0;
                end else if (has_up || has_dn) begin
                    dir_d   = has_up && (!has_dn || (du <= dd));
                    state_d = S_MOVING;
                    timer_d = '0;
                end
            end
            S_MOVING: begin
                if (tick) begin
                    if (timer_q == TW'(MOVE_TICKS - 1)) begin
                        floor_d = step_floor;
                        timer_d = '0;
                        if (pend_eff[step_floor]) begin
                            pending_d[step_floor] = 1'b0;
                            state_d               = S_DOOR_OPEN;
                        end else if (!ahead_n) begin
                            if (behind_n) dir_d = !dir_q;
                            else          state_d = S_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_DOOR_OPEN: begin
                if (door_restart || hold_in) begin
                    timer_d = '0;
                end else if (tick) begin
                    if (timer_q == TW'(DOOR_TICKS - 1)) begin
                        state_d = S_DOOR_CLOSING;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_DOOR_CLOSING: begin
                if (hold_in) begin
                    state_d = S_DOOR_OPEN;
                    timer_d = '0;
                end else if (tick) begin
                    timer_d = '0;
                    if (pend_eff[floor_q]) begin
                        pending_d[floor_q] = 1'b0;
                        state_d            = S_DOOR_OPEN;
                    end else if (has_up || has_dn) begin
                        dir_d   = dir_q ? has_up : !has_dn;
                        state_d = S_MOVING;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || tick || (hold_in && (state_q == S_DOOR_OPEN))) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State, position, direction, call and timer registers.
    always_ff @(posedge clk10hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            dir_q     <= 1'b1;
            pending_q <= '0;
            timer_q   <= '0;
            presc_q   <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            presc_q   <= presc_d;
        end
    end

    assign curr_floor    = floor_q;
    assign pending       = pending_q;
    assign state         = state_q;
    assign running_state = (state_q == S_MOVING) ? (dir_q ? 2'b01 : 2'b10) : 2'b00;
    assign door_state    = (state_q == S_DOOR_OPEN)    ? 2'b01 :
                           (state_q == S_DOOR_CLOSING) ? 2'b10 : 2'b00;

endmodule
